// File: rtl/aes_round_pipe_pkg.sv
// Shared definitions for the AES round pipeline: FSM encoding, Rcon table,
// byte/word index helpers, legal-LANES check and GF(2^8) S-box arithmetic.
package aes_round_pipe_pkg;

    typedef enum logic [1:0] {IDLE, SBOX, KEY, HOLD} state_t;

    // Round constant for key expansion; rounds above 9 use 00.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte n of a 128-bit state lives at bits [8n+7:8n].
    function automatic logic [7:0] get_byte(input logic [127:0] v, input logic [3:0] n);
        return v[8*n +: 8];
    endfunction

    // Column c of a 128-bit state lives at bits [32c+31:32c].
    function automatic logic [31:0] get_col(input logic [127:0] v, input logic [1:0] c);
        return v[32*c +: 32];
    endfunction

    function automatic bit lanes_ok(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4);
    endfunction

    // Rotate a column left by r byte positions (byte k moves to byte k+r).
    function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] r);
        case (r)
            2'd0:    return w;
            2'd1:    return {w[23:0], w[31:24]};
            2'd2:    return {w[15:0], w[31:16]};
            default: return {w[7:0], w[31:8]};
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as b^254 (0 maps to 0), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_lookup_lanes.sv
// LANES parallel T-box lookups: LANES 8-bit indices in, LANES T-words out.
module aes_lookup_lanes #(
    parameter int LANES = 1
) (
    input  logic [LANES*8-1:0]  idx,
    output logic [LANES*32-1:0] tword
);
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        tbox0 u_tbox0 (
            .idx   (idx[8*l +: 8]),
            .tword (tword[32*l +: 32])
        );
    end
endmodule

// File: rtl/shiftrows.sv
// AES ShiftRows on a column-major state: row r is rotated left by r columns.
module shiftrows (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign dout[8*(4*c + r) +: 8] = din[8*(4*((c + r) % 4) + r) +: 8];
        end
    end
endmodule

// File: rtl/tbox0.sv
// T-box 0: for S = sbox(idx) returns {3S, S, S, 2S}, i.e. the MixColumns
// contribution of a row-0 byte; the plain S-box value sits in bits [15:8].
module tbox0
    import aes_round_pipe_pkg::*;
(
    input  logic [7:0]  idx,
    output logic [31:0] tword
);
    logic [7:0] s;
    logic [7:0] s2;

    assign s     = sbox(idx);
    assign s2    = xtime(s);
    assign tword = {s2 ^ s, s, s, s2};
endmodule

// File: rtl/aes_round_pipe.sv
// One AES-128 encryption round per transaction with LANES lookups per cycle.
// Bytes of ShiftRows(state) are looked up in SBOX and folded column by column
// (T-box MixColumns, or plain S-box on the final round); KEY substitutes
// RotWord(w3) and expands the key; the result is held in HOLD until taken.
module aes_round_pipe
    import aes_round_pipe_pkg::*;
#(
    parameter int LANES       = 1,
    parameter int FINAL_ROUND = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] i_text,
    input  logic [127:0] key,
    input  logic [3:0]   round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] o_text,
    output logic [127:0] Rkey,
    output logic         busy
);
    if (!lanes_ok(LANES)) begin : g_lanes_check
        $error("aes_round_pipe: LANES must be 1, 2 or 4");
    end

    localparam int SBOX_CYC   = 16 / LANES;
    localparam int KEY_CYC    = 4 / LANES;
    localparam int LANE_SHIFT = $clog2(LANES);

    state_t              state;
    logic [3:0]          cnt;
    logic [127:0]        text_q;
    logic [127:0]        key_q;
    logic [3:0]          round_q;
    logic [127:0]        mix_q;
    logic [31:0]         acc_q;
    logic [31:0]         sub_q;

    logic [127:0]        sr_text;
    logic [3:0]          base;
    logic                is_final;
    logic                accept;
    logic [LANES*8-1:0]  lut_idx;
    logic [LANES*32-1:0] lut_word;
    logic [31:0]         acc_next;
    logic [31:0]         sub_next;
    logic [127:0]        exp_key;

    assign base     = cnt << LANE_SHIFT;
    assign is_final = (round_q == 4'(FINAL_ROUND));
    assign accept   = (state == IDLE) && in_ready && in_valid;

    shiftrows u_shiftrows (
        .din  (text_q),
        .dout (sr_text)
    );

    aes_lookup_lanes #(.LANES(LANES)) u_lanes (
        .idx   (lut_idx),
        .tword (lut_word)
    );

    // Pick this cycle's lookup bytes: ShiftRows(state) in SBOX, RotWord(w3) in KEY.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no latch is inferred.
        lut_idx = '0;
        for (int l = 0; l < LANES; l++) begin
            if (state == KEY)
                lut_idx[8*l +: 8] = get_byte(key_q, {2'b11, 2'(base[1:0] + 2'(l) + 2'd1)});
            else
                lut_idx[8*l +: 8] = get_byte(sr_text, base + 4'(l));
        end
    end

    // Fold lookups into the column accumulator and SubWord, then expand the key.
    always_comb begin
        logic [1:0] row;
        logic [7:0] s;
        row      = '0;
        s        = '0;
        acc_next = (base[1:0] == 2'd0) ? '0 : acc_q;
        sub_next = sub_q;
        for (int l = 0; l < LANES; l++) begin
            row = base[1:0] + 2'(l);
            s   = lut_word[32*l + 8 +: 8];
            if (is_final)
                acc_next[8*row +: 8] = s;
            else
                acc_next = acc_next ^ rotl_bytes(lut_word[32*l +: 32], row);
            sub_next[8*row +: 8] = s;
        end
        exp_key        = '0;
        exp_key[31:0]  = get_col(key_q, 2'd0) ^ sub_next ^ {24'h0, rcon(round_q)};
        for (int i = 1; i < 4; i++)
            exp_key[32*i +: 32] = get_col(key_q, 2'(i)) ^ exp_key[32*(i-1) +: 32];
    end

    // Capture the request and store partial column and SubWord results.
    always_ff @(posedge clock) begin
        // NOTE: datapath registers carry no reset; each is loaded before it is read.
        if (accept) begin
            text_q  <= i_text;
            key_q   <= key;
            round_q <= round;
        end
        if (state == SBOX) begin
            acc_q <= acc_next;
            if ((base[1:0] + 2'(LANES - 1)) == 2'd3)
                mix_q[32*base[3:2] +: 32] <= acc_next;
        end
        if (state == KEY)
            sub_q <= sub_next;
    end

    // Control FSM with registered handshake outputs and results.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            o_text    <= '0;
            Rkey      <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= SBOX;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SBOX: begin
                    if (cnt == 4'(SBOX_CYC - 1)) begin
                        state <= KEY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                KEY: begin
                    if (cnt == 4'(KEY_CYC - 1)) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        o_text    <= mix_q ^ exp_key;
                        Rkey      <= exp_key;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_pipe.sv
// Bench for aes_round_pipe: three instances (LANES = 1, 2, 4) share the
// request/handshake inputs; results are compared with FIPS-197 vectors and
// with a byte-array AES round model.
module tb_aes_round_pipe;

    localparam logic [127:0] T1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] T1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] T1_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] T1_RK  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] T2_IN  = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] T2_KEY = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] T2_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] T2_RK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] i_text;
    logic [127:0] key;
    logic [3:0]   round;

    logic         ir [3];
    logic         ov [3];
    logic         bz [3];
    logic [127:0] ot [3];
    logic [127:0] rk [3];

    int errors = 0;
    int checks = 0;

    logic [7:0] sbox_t [256];

    aes_round_pipe #(.LANES(1)) u_l1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
        .i_text(i_text), .key(key), .round(round), .out_valid(ov[0]),
        .out_ready(out_ready), .o_text(ot[0]), .Rkey(rk[0]), .busy(bz[0]));
    aes_round_pipe #(.LANES(2)) u_l2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
        .i_text(i_text), .key(key), .round(round), .out_valid(ov[1]),
        .out_ready(out_ready), .o_text(ot[1]), .Rkey(rk[1]), .busy(bz[1]));
    aes_round_pipe #(.LANES(4)) u_l4 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
        .i_text(i_text), .key(key), .round(round), .out_valid(ov[2]),
        .out_ready(out_ready), .o_text(ot[2]), .Rkey(rk[2]), .busy(bz[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // FIPS-197 listing order (first byte leftmost) to byte-n-at-[8n+7:8n].
    function automatic logic [127:0] fips(input logic [127:0] v);
        logic [127:0] r;
        for (int n = 0; n < 16; n++) r[8*n +: 8] = v[8*(15-n) +: 8];
        return r;
    endfunction

    // Carry-less multiply followed by reduction modulo 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox_t[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] rcon_ref(input logic [3:0] r);
        logic [7:0] tbl [10];
        tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        return (r <= 4'd9) ? tbl[r] : 8'h00;
    endfunction

    // Reference AES round on byte arrays.
    function automatic void model_round(input logic [127:0] t, input logic [127:0] k,
                                        input logic [3:0] r,
                                        output logic [127:0] o, output logic [127:0] rko);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] w [16];
        logic [7:0] tmp [4];
        logic [7:0] x0, x1, x2, x3;
        for (int n = 0; n < 16; n++) a[n] = sbox_t[t[8*n +: 8]];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                b[4*c + row] = a[4*((c + row) % 4) + row];
        if (r != 4'd9) begin
            for (int c = 0; c < 4; c++) begin
                x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
                b[4*c]   = gmul(8'h02, x0) ^ gmul(8'h03, x1) ^ x2 ^ x3;
                b[4*c+1] = x0 ^ gmul(8'h02, x1) ^ gmul(8'h03, x2) ^ x3;
                b[4*c+2] = x0 ^ x1 ^ gmul(8'h02, x2) ^ gmul(8'h03, x3);
                b[4*c+3] = gmul(8'h03, x0) ^ x1 ^ x2 ^ gmul(8'h02, x3);
            end
        end
        tmp[0] = sbox_t[k[8*13 +: 8]] ^ rcon_ref(r);
        tmp[1] = sbox_t[k[8*14 +: 8]];
        tmp[2] = sbox_t[k[8*15 +: 8]];
        tmp[3] = sbox_t[k[8*12 +: 8]];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[4*i + j] = k[8*(4*i + j) +: 8] ^ ((i == 0) ? tmp[j] : w[4*(i-1) + j]);
        for (int n = 0; n < 16; n++) begin
            o[8*n +: 8]   = b[n] ^ w[n];
            rko[8*n +: 8] = w[n];
        end
    endfunction

    task automatic issue(input logic [127:0] t, input logic [127:0] k, input logic [3:0] r);
        i_text   = t;
        key      = k;
        round    = r;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every instance shows out_valid; optionally scramble inputs.
    task automatic wait_all(input bit scramble);
        int n;
        n = 0;
        while (!(ov[0] && ov[1] && ov[2]) && n < 60) begin
            if (scramble) begin
                i_text = {$urandom, $urandom, $urandom, $urandom};
                key    = {$urandom, $urandom, $urandom, $urandom};
                round  = 4'($urandom);
            end
            @(negedge clock);
            n++;
        end
        check("wait_timeout", 128'(n < 60), 128'(1));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        for (int l = 0; l < 3; l++) begin
            check($sformatf("rel_out_valid_l%0d", 1 << l), 128'(ov[l]), 128'(0));
            check($sformatf("rel_in_ready_l%0d", 1 << l), 128'(ir[l]), 128'(1));
            check($sformatf("rel_busy_l%0d", 1 << l), 128'(bz[l]), 128'(0));
        end
    endtask

    task automatic check_result(input string tag, input logic [127:0] eo, input logic [127:0] er);
        for (int l = 0; l < 3; l++) begin
            check($sformatf("%s_o_text_l%0d", tag, 1 << l), ot[l], eo);
            check($sformatf("%s_rkey_l%0d", tag, 1 << l), rk[l], er);
        end
    endtask

    initial begin
        int lat [3];
        logic [127:0] mt, mk, mo, mr;
        logic [3:0]   r;

        build_sbox();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        i_text = '0; key = '0; round = '0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        for (int l = 0; l < 3; l++) begin
            check($sformatf("rst_in_ready_l%0d", 1 << l), 128'(ir[l]), 128'(0));
            check($sformatf("rst_out_valid_l%0d", 1 << l), 128'(ov[l]), 128'(0));
            check($sformatf("rst_o_text_l%0d", 1 << l), ot[l], 128'(0));
            check($sformatf("rst_rkey_l%0d", 1 << l), rk[l], 128'(0));
            check($sformatf("rst_busy_l%0d", 1 << l), 128'(bz[l]), 128'(0));
        end
        reset = 1'b0;
        @(negedge clock);
        for (int l = 0; l < 3; l++)
            check($sformatf("post_rst_in_ready_l%0d", 1 << l), 128'(ir[l]), 128'(1));

        // Round 0 vector and latency per lane count
        issue(fips(T1_IN), fips(T1_KEY), 4'd0);
        for (int l = 0; l < 3; l++) begin
            check($sformatf("busy_after_accept_l%0d", 1 << l), 128'(bz[l]), 128'(1));
            check($sformatf("in_ready_after_accept_l%0d", 1 << l), 128'(ir[l]), 128'(0));
            lat[l] = 0;
        end
        for (int n = 2; n <= 26; n++) begin
            @(negedge clock);
            for (int l = 0; l < 3; l++)
                if (lat[l] == 0 && ov[l]) lat[l] = n;
        end
        for (int l = 0; l < 3; l++)
            check($sformatf("latency_l%0d", 1 << l), 128'(lat[l]), 128'(20 / (1 << l) + 1));
        check_result("t1", fips(T1_OUT), fips(T1_RK));

        // Backpressure: result stable, requests ignored while held
        for (int c = 0; c < 10; c++) begin
            in_valid = (c % 2 == 0);
            i_text   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clock);
            for (int l = 0; l < 3; l++) begin
                check($sformatf("hold_out_valid_l%0d", 1 << l), 128'(ov[l]), 128'(1));
                check($sformatf("hold_in_ready_l%0d", 1 << l), 128'(ir[l]), 128'(0));
            end
            check_result("hold", fips(T1_OUT), fips(T1_RK));
        end
        in_valid = 1'b0;
        release_out();

        // Final round vector
        issue(fips(T2_IN), fips(T2_KEY), 4'd9);
        wait_all(1'b0);
        check_result("final", fips(T2_OUT), fips(T2_RK));
        release_out();

        // Inputs changing every cycle while busy
        issue(fips(T1_IN), fips(T1_KEY), 4'd0);
        wait_all(1'b1);
        check_result("scramble", fips(T1_OUT), fips(T1_RK));
        release_out();

        // Reset in the middle of SBOX
        issue(fips(T1_IN), fips(T1_KEY), 4'd0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int l = 0; l < 3; l++) begin
            check($sformatf("midrst_out_valid_l%0d", 1 << l), 128'(ov[l]), 128'(0));
            check($sformatf("midrst_busy_l%0d", 1 << l), 128'(bz[l]), 128'(0));
        end
        check_result("midrst", 128'(0), 128'(0));
        reset = 1'b0;
        @(negedge clock);
        for (int l = 0; l < 3; l++)
            check($sformatf("midrst_in_ready_l%0d", 1 << l), 128'(ir[l]), 128'(1));

        // Random requests, including round 9 and rounds above 9
        for (int i = 0; i < 7; i++) begin
            mt = {$urandom, $urandom, $urandom, $urandom};
            mk = {$urandom, $urandom, $urandom, $urandom};
            r  = (i == 0) ? 4'd12 : (i == 1) ? 4'd9 : 4'($urandom_range(15, 0));
            model_round(mt, mk, r, mo, mr);
            issue(mt, mk, r);
            wait_all(1'b0);
            check_result($sformatf("rand%0d", i), mo, mr);
            release_out();
        end

        // Full cipher: rounds 0..9 chained through the LANES=1 outputs
        mt = fips(T1_IN);
        mk = fips(T1_KEY);
        for (int i = 0; i < 10; i++) begin
            model_round(mt, mk, 4'(i), mo, mr);
            issue(ot[0] ^ ot[0] ^ mt, rk[0] ^ rk[0] ^ mk, 4'(i));
            wait_all(1'b0);
            check_result($sformatf("chain%0d", i), mo, mr);
            mt = ot[0];
            mk = rk[0];
            release_out();
        end
        check("chain_ciphertext", mt, fips(T2_OUT));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_round_pipe.md
Name: aes_round_pipe

Overview:
- Parametrised successor to the single-lane AES-128 encryption round unit.
- Executes one full encryption round per transaction: SubBytes, ShiftRows, MixColumns (skipped on the final round), key expansion and AddRoundKey.
- The number of S-box/T-box lookups per cycle is set by LANES, which trades area against latency.
- Uses a valid/ready handshake on both sides (in place of a bare enable/done), with results held until consumed; sits between the round-sequencing controller and the state/key registers.

Parameters:
- LANES, 1, lookups per cycle; legal values 1, 2, 4 (elaboration error otherwise).
- FINAL_ROUND, 9, round index at which MixColumns is bypassed.

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- i_text  in  128  round input state; byte n at bits [8n+7:8n], column-major (FIPS-197 byte order)
- key  in  128  previous round key, same byte mapping
- round  in  4  round index 0..9; selects Rcon and the final-round mode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- o_text  out  128  round output state
- Rkey  out  128  expanded round key for this round
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: in_ready=0 during the reset cycle and 1 in the cycle after; out_valid=0; o_text=0; Rkey=0; busy=0; FSM goes to IDLE.
- FSM states: IDLE, SBOX, KEY, HOLD.
- IDLE: in_ready=1. On in_valid, capture i_text, key and round into internal registers, go to SBOX, set counter=0.
- Inputs are not sampled again until the next acceptance; they may change freely while busy.
- SBOX: 16/LANES cycles. Each cycle looks up LANES consecutive bytes of ShiftRows(state), byte indices counter*LANES .. +LANES-1.
- A completed column (4 bytes) is combined and stored:
  - round != FINAL_ROUND: MixColumns of the column.
  - round == FINAL_ROUND: the substituted bytes only.
- KEY: 4/LANES cycles. Looks up the bytes of RotWord(w3) = key bytes 13, 14, 15, 12, producing SubWord. Then:
  - w0' = key[31:0] ^ SubWord ^ {24'h0, Rcon[round]}
  - wi' = key word i ^ w(i-1)', for i = 1..3
- Rcon table: 01,02,04,08,10,20,40,80,1b,36. A round value above 9 uses Rcon 00 and does not flag an error.
- Exit from KEY (registered):
  - o_text <= column results ^ expanded key
  - Rkey <= expanded key
  - out_valid <= 1, go to HOLD
- Latency from acceptance to out_valid: 20/LANES + 1 cycles (21, 11, 6).
- HOLD:
  - o_text and Rkey are stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid <= 0, return to IDLE.
  - in_ready stays 0 in HOLD. There is no overlap: the next request is accepted at the earliest one cycle after the output handshake.
- in_valid while not in IDLE is ignored; the producer must hold it until in_ready.
- out_ready while out_valid=0 has no effect.
- Reset mid-operation (any state): transaction abandoned, outputs return to reset values, no out_valid produced.
- All XOR/GF(2^8) arithmetic is 8-bit. xtime uses reduction polynomial 0x11b. No carries cross byte boundaries.

Decomposition:
- Shared package holds:
  - the Rcon table
  - the FSM state encoding
  - byte/word index helpers (column c = bits [32c+31:32c])
  - the legal-LANES check function
- Reuse the existing shiftrows module unchanged.
- One natural new sub-module: aes_lookup_lanes. It instantiates the existing tbox0 LANES times, takes LANES×8-bit indices and returns LANES T-words; the S-box value is taken from bits [15:8].
- MixColumns combine and key expansion stay in the top module.

Test Plan:
- LANES=1/2/4: i_text=193de3bea0f4e22b9ac68d2ae9f84808, key=2b7e151628aed2a6abf7158809cf4f3c, round=0 (FIPS-197 byte order) -> o_text=a49c7ff2689f352b6b5bea43026a5049, Rkey=a0fafe1788542cb123a339392a6c7605, out_valid exactly 21/11/6 cycles after acceptance.
- Final round: i_text=eb40f21e592e38848ba113e71bc342d2, key=ac7766f319fadc2128d12941575c006e, round=9 -> o_text=3925841d02dc09fbdc118597196a0b32, Rkey=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> o_text/Rkey stable, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> out_valid falls next cycle, in_ready=1.
- Input change while busy: alter i_text/key/round every cycle after acceptance -> result still equals the first-test vector.
- Reset asserted mid-SBOX (LANES=1, cycle 7) -> next cycle out_valid=0, o_text=0, Rkey=0, busy=0; a fresh request then completes correctly.
- Back-to-back chain: feed each o_text/Rkey back with round 0..9 starting from the test-1 inputs -> final o_text=3925841d02dc09fbdc118597196a0b32.
